// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//   Pipeline MEM stage. Owns the data memory (2**ADDR_WIDTH x 16) and the stack
//   pointer. Sequences PC push (CALL/INT) and PC pop (RET/RTI) as several
//   16-bit words, holding upstream with a combinational stall while it does so.
//
//   Optional feature macro: FLAG_SAVE_EN
//     defined   : push with src 11 also saves {13'b0,flags} (3 words), a PC pop
//                 restores three words (low, high, flags) and reports the flags.
//     undefined : src 11 behaves as src 10, flag outputs are tied to zero.
//
// Ports
//   clk, reset                     clock (rising edge), async active-low reset
//   alu_result, read_data1/2       EX/MEM operands (address / write data)
//   pc_plus_one, flag_register     return address and {C,N,Z} for CALL/INT
//   mem_read/write/push/pop        memory operation controls
//   memory_address_select          00 alu_result, 01 read_data1, else 00
//   memory_write_src_select        00 rd1, 01 rd2, 10 PC, 11 PC + flags
//   pc_choose_memory               pop is a PC return
//   reg_write, outport_enable,
//   wb_sel, reg_write_address      forwarded to MEM/WB
//   stall                          upstream holds EX/MEM inputs while high
//   mem_data_out ... reg_write_address_out   MEM/WB buffer
//   pc_from_memory(_valid)         popped PC and its one-cycle pulse
//   conditions_from_memory_pop,
//   flags_from_memory_valid        popped flags and their one-cycle pulse
//   sp_out                         current stack pointer
// -----------------------------------------------------------------------------
module memory_stage #(
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           alu_result,
   input  logic [15:0]           read_data1,
   input  logic [15:0]           read_data2,
   input  logic [31:0]           pc_plus_one,
   input  logic [2:0]            flag_register,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  mem_push,
   input  logic                  mem_pop,
   input  logic [1:0]            memory_address_select,
   input  logic [1:0]            memory_write_src_select,
   input  logic                  pc_choose_memory,
   input  logic                  reg_write,
   input  logic                  outport_enable,
   input  logic [1:0]            wb_sel,
   input  logic [2:0]            reg_write_address,
   output logic                  stall,
   output logic [15:0]           mem_data_out,
   output logic [15:0]           alu_result_out,
   output logic                  reg_write_out,
   output logic                  outport_enable_out,
   output logic [1:0]            wb_sel_out,
   output logic [2:0]            reg_write_address_out,
   output logic [31:0]           pc_from_memory,
   output logic                  pc_from_memory_valid,
   output logic [2:0]            conditions_from_memory_pop,
   output logic                  flags_from_memory_valid,
   output logic [ADDR_WIDTH-1:0] sp_out
);

   localparam int unsigned           LP_DEPTH  = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LP_SP_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

`ifdef FLAG_SAVE_EN
   typedef enum logic [1:0] {IDLE, WORD2, WORD3} state_t;
`else
   typedef enum logic [1:0] {IDLE, WORD2} state_t;
`endif

   state_t                  r_state;
   state_t                  w_state_next;

   logic [15:0]             r_mem [LP_DEPTH];
   logic [ADDR_WIDTH-1:0]   r_sp;
   logic                    r_seq_push;
   logic [15:0]             r_pc_lo;
   logic [31:0]             r_pc_out;
   logic                    r_pc_valid;
   logic [15:0]             r_mem_data;
   logic [15:0]             r_alu_result;
   logic                    r_reg_write;
   logic                    r_outport_enable;
   logic [1:0]              r_wb_sel;
   logic [2:0]              r_reg_write_address;

   logic [ADDR_WIDTH-1:0]   w_sp_next;
   logic [ADDR_WIDTH-1:0]   w_sel_addr;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [15:0]             w_rdata;
   logic [15:0]             w_wdata;
   logic [15:0]             w_src_word;
   logic [15:0]             w_push_first;
   logic                    w_we;
   logic                    w_sp_dec;
   logic                    w_sp_inc;
   logic                    w_stall;
   logic                    w_load_lo;
   logic                    w_pc_done;
   logic [15:0]             w_pc_hi;
   logic                    w_unused;

`ifdef FLAG_SAVE_EN
   logic                    r_seq_flags;
   logic [15:0]             r_pc_hi;
   logic [2:0]              r_flags_out;
   logic                    r_flags_valid;
   logic                    w_load_hi;
`endif

   assign w_sp_next  = r_sp + LP_SP_ONE;
   assign w_sel_addr = (memory_address_select == 2'b01) ? read_data1[ADDR_WIDTH-1:0]
                                                        : alu_result[ADDR_WIDTH-1:0];
   assign w_src_word = (memory_write_src_select == 2'b00) ? read_data1 :
                       (memory_write_src_select == 2'b01) ? read_data2 :
                                                            pc_plus_one[15:0];

   // First word of a push: plain data for src 0x, the PC high word for src 10,
   // and the saved flags for src 11 when flag saving is built in.
`ifdef FLAG_SAVE_EN
   assign w_push_first = !memory_write_src_select[1]        ? w_src_word :
                         (memory_write_src_select == 2'b11) ? {13'b0, flag_register} :
                                                              pc_plus_one[31:16];
   assign w_pc_hi      = r_pc_hi;
   assign w_unused     = mem_read;
`else
   assign w_push_first = memory_write_src_select[1] ? pc_plus_one[31:16] : w_src_word;
   assign w_pc_hi      = w_rdata;
   assign w_unused     = ^{mem_read, flag_register};
`endif

   // A read is simply the default action, so mem_read needs no decode.
   assign w_rdata = r_mem[w_addr];

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (mem_push) begin
               if (memory_write_src_select[1]) w_state_next = WORD2;
            end else if (mem_pop && pc_choose_memory) begin
               w_state_next = WORD2;
            end
         end
`ifdef FLAG_SAVE_EN
         WORD2: w_state_next = (!r_seq_push || r_seq_flags) ? WORD3 : IDLE;
         WORD3: w_state_next = IDLE;
`else
         WORD2: w_state_next = IDLE;
`endif
         default: w_state_next = IDLE;
      endcase
   end

   // ----------------------------------------------------------- output decode
   always_comb begin
      w_addr    = w_sel_addr;
      w_we      = 1'b0;
      w_wdata   = w_src_word;
      w_sp_dec  = 1'b0;
      w_sp_inc  = 1'b0;
      w_stall   = 1'b0;
      w_load_lo = 1'b0;
      w_pc_done = 1'b0;
`ifdef FLAG_SAVE_EN
      w_load_hi = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (mem_push) begin
               w_addr   = r_sp;
               w_we     = 1'b1;
               w_wdata  = w_push_first;
               w_sp_dec = 1'b1;
               w_stall  = memory_write_src_select[1];
            end else if (mem_pop) begin
               w_addr    = w_sp_next;
               w_sp_inc  = 1'b1;
               w_load_lo = pc_choose_memory;
               w_stall   = pc_choose_memory;
            end else if (mem_write) begin
               w_we = 1'b1;
            end
         end
         WORD2: begin
            if (r_seq_push) begin
               w_addr   = r_sp;
               w_we     = 1'b1;
               w_sp_dec = 1'b1;
`ifdef FLAG_SAVE_EN
               w_wdata  = r_seq_flags ? pc_plus_one[31:16] : pc_plus_one[15:0];
               w_stall  = r_seq_flags;
`else
               w_wdata  = pc_plus_one[15:0];
`endif
            end else begin
               w_addr   = w_sp_next;
               w_sp_inc = 1'b1;
`ifdef FLAG_SAVE_EN
               w_load_hi = 1'b1;
               w_stall   = 1'b1;
`else
               w_pc_done = 1'b1;
`endif
            end
         end
`ifdef FLAG_SAVE_EN
         WORD3: begin
            if (r_seq_push) begin
               w_addr   = r_sp;
               w_we     = 1'b1;
               w_wdata  = pc_plus_one[15:0];
               w_sp_dec = 1'b1;
            end else begin
               w_addr    = w_sp_next;
               w_sp_inc  = 1'b1;
               w_pc_done = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   // ---------------------------------------------------------- data memory
   // Not reset: contents survive a reset of the stage.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_addr] <= w_wdata;
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sp                <= '1;
         r_seq_push          <= 1'b0;
         r_pc_lo             <= '0;
         r_pc_out            <= '0;
         r_pc_valid          <= 1'b0;
         r_mem_data          <= '0;
         r_alu_result        <= '0;
         r_reg_write         <= 1'b0;
         r_outport_enable    <= 1'b0;
         r_wb_sel            <= '0;
         r_reg_write_address <= '0;
`ifdef FLAG_SAVE_EN
         r_seq_flags         <= 1'b0;
         r_pc_hi             <= '0;
         r_flags_out         <= '0;
         r_flags_valid       <= 1'b0;
`endif
      end else begin
         if (w_sp_dec)      r_sp <= r_sp - LP_SP_ONE;
         else if (w_sp_inc) r_sp <= w_sp_next;

         if (r_state == IDLE) begin
            r_seq_push  <= mem_push;
`ifdef FLAG_SAVE_EN
            r_seq_flags <= mem_push && (memory_write_src_select == 2'b11);
`endif
         end

         if (w_load_lo) r_pc_lo  <= w_rdata;
         if (w_pc_done) r_pc_out <= {w_pc_hi, r_pc_lo};
         r_pc_valid <= w_pc_done;
`ifdef FLAG_SAVE_EN
         if (w_load_hi) r_pc_hi     <= w_rdata;
         if (w_pc_done) r_flags_out <= w_rdata[2:0];
         r_flags_valid <= w_pc_done;
`endif

         // MEM/WB: intermediate cycles of a multi-word op carry a bubble.
         r_mem_data          <= w_rdata;
         r_alu_result        <= alu_result;
         r_reg_write         <= reg_write & ~w_stall;
         r_outport_enable    <= outport_enable & ~w_stall;
         r_wb_sel            <= wb_sel;
         r_reg_write_address <= reg_write_address;
      end
   end

   assign stall                 = w_stall;
   assign mem_data_out          = r_mem_data;
   assign alu_result_out        = r_alu_result;
   assign reg_write_out         = r_reg_write;
   assign outport_enable_out    = r_outport_enable;
   assign wb_sel_out            = r_wb_sel;
   assign reg_write_address_out = r_reg_write_address;
   assign pc_from_memory        = r_pc_out;
   assign pc_from_memory_valid  = r_pc_valid;
   assign sp_out                = r_sp;
`ifdef FLAG_SAVE_EN
   assign conditions_from_memory_pop = r_flags_out;
   assign flags_from_memory_valid    = r_flags_valid;
`else
   assign conditions_from_memory_pop = '0;
   assign flags_from_memory_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

   localparam int unsigned AW     = 12;
   localparam int unsigned DEPTH  = 1 << AW;
   localparam logic [AW-1:0] SP_RST = 12'hFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] alu_result, read_data1, read_data2;
   logic [31:0] pc_plus_one;
   logic [2:0]  flag_register;
   logic        mem_read, mem_write, mem_push, mem_pop;
   logic [1:0]  memory_address_select, memory_write_src_select;
   logic        pc_choose_memory, reg_write, outport_enable;
   logic [1:0]  wb_sel;
   logic [2:0]  reg_write_address;
   logic        stall;
   logic [15:0] mem_data_out, alu_result_out;
   logic        reg_write_out, outport_enable_out;
   logic [1:0]  wb_sel_out;
   logic [2:0]  reg_write_address_out;
   logic [31:0] pc_from_memory;
   logic        pc_from_memory_valid;
   logic [2:0]  conditions_from_memory_pop;
   logic        flags_from_memory_valid;
   logic [AW-1:0] sp_out;

   memory_stage #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .alu_result(alu_result), .read_data1(read_data1), .read_data2(read_data2),
      .pc_plus_one(pc_plus_one), .flag_register(flag_register),
      .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
      .memory_address_select(memory_address_select),
      .memory_write_src_select(memory_write_src_select),
      .pc_choose_memory(pc_choose_memory), .reg_write(reg_write),
      .outport_enable(outport_enable), .wb_sel(wb_sel),
      .reg_write_address(reg_write_address), .stall(stall),
      .mem_data_out(mem_data_out), .alu_result_out(alu_result_out),
      .reg_write_out(reg_write_out), .outport_enable_out(outport_enable_out),
      .wb_sel_out(wb_sel_out), .reg_write_address_out(reg_write_address_out),
      .pc_from_memory(pc_from_memory), .pc_from_memory_valid(pc_from_memory_valid),
      .conditions_from_memory_pop(conditions_from_memory_pop),
      .flags_from_memory_valid(flags_from_memory_valid), .sp_out(sp_out)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: word memory plus stack pointer, wrapping mod DEPTH.
   logic [15:0]   m_mem [DEPTH];
   logic [AW-1:0] m_sp;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_read = 1'b0; mem_write = 1'b0; mem_push = 1'b0; mem_pop = 1'b0;
      memory_address_select = 2'b00; memory_write_src_select = 2'b00;
      pc_choose_memory = 1'b0; reg_write = 1'b0; outport_enable = 1'b0;
   endtask

   // Presents address a through a randomly chosen select path with random
   // pass-through fields; upper operand bits are random and must be ignored.
   task automatic drive_read(input logic [AW-1:0] a);
      idle_inputs();
      mem_read = 1'b1;
      memory_address_select = 2'($urandom);
      if (memory_address_select == 2'b01) begin
         read_data1 = {4'($urandom), a};
         alu_result = 16'($urandom);
      end else begin
         alu_result = {4'($urandom), a};
         read_data1 = 16'($urandom);
      end
      reg_write = 1'($urandom); outport_enable = 1'($urandom);
      wb_sel = 2'($urandom); reg_write_address = 3'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      alu_result = 16'hFFFF; reg_write = 1'b1; outport_enable = 1'b1;
      wb_sel = 2'b11; reg_write_address = 3'b111;
      tick(); tick();
      n_vec++;
      if (sp_out !== SP_RST) begin
         n_err++; $display("FAIL reset_sp: got %h want %h", sp_out, SP_RST);
      end
      n_vec++;
      if ({stall, mem_data_out, alu_result_out, reg_write_out, outport_enable_out,
           wb_sel_out, reg_write_address_out, pc_from_memory, pc_from_memory_valid,
           conditions_from_memory_pop, flags_from_memory_valid} !== 77'd0) begin
         n_err++; $display("FAIL reset_outputs: got nonzero (alu_out=%h rw=%b pc=%h) want all 0",
                           alu_result_out, reg_write_out, pc_from_memory);
      end
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      tick();
      m_sp = SP_RST;
   endtask

   task automatic test_store_load();
      logic [AW-1:0] addrs[$];
      logic [AW-1:0] a;
      // STD then LDD at 0x010.
      idle_inputs();
      mem_write = 1'b1; alu_result = 16'h0010; read_data1 = 16'hBEEF;
      tick();
      m_mem[12'h010] = 16'hBEEF;
      drive_read(12'h010);
      tick();
      n_vec++;
      if (mem_data_out !== 16'hBEEF) begin
         n_err++; $display("FAIL ldd_0010: got %h want BEEF", mem_data_out);
      end
      // Random stores through both address paths and both data sources.
      for (int i = 0; i < 16; i++) begin
         a = AW'($urandom_range(12'hEFF, 12'h020));
         idle_inputs();
         mem_write = 1'b1;
         memory_address_select = 2'($urandom);
         memory_write_src_select = 2'($urandom_range(1, 0));
         read_data2 = 16'($urandom);
         if (memory_address_select == 2'b01) begin
            read_data1 = {4'($urandom), a}; alu_result = 16'($urandom);
         end else begin
            alu_result = {4'($urandom), a}; read_data1 = 16'($urandom);
         end
         tick();
         m_mem[a] = memory_write_src_select[0] ? read_data2 : read_data1;
         addrs.push_back(a);
      end
      foreach (addrs[i]) begin
         drive_read(addrs[i]);
         tick();
         n_vec++;
         if (mem_data_out !== m_mem[addrs[i]]) begin
            n_err++; $display("FAIL load_rand: addr %h got %h want %h",
                              addrs[i], mem_data_out, m_mem[addrs[i]]);
         end
         n_vec++;
         if ({alu_result_out, reg_write_out, outport_enable_out, wb_sel_out, reg_write_address_out}
             !== {alu_result, reg_write, outport_enable, wb_sel, reg_write_address}) begin
            n_err++; $display("FAIL memwb_pass: got %h/%b%b%b%b want %h/%b%b%b%b",
                              alu_result_out, reg_write_out, outport_enable_out, wb_sel_out,
                              reg_write_address_out, alu_result, reg_write, outport_enable,
                              wb_sel, reg_write_address);
         end
      end
   endtask

   task automatic test_push_pop();
      logic [15:0] d;
      int unsigned k;
      // SP wrap: pop at 0xFFF reads mem[0] and lands on 0; a push wraps back.
      idle_inputs();
      mem_write = 1'b1; alu_result = 16'h0000; read_data1 = 16'hA5A5;
      tick();
      m_mem[0] = 16'hA5A5;
      idle_inputs(); mem_pop = 1'b1;
      tick();
      m_sp = m_sp + 1'b1;
      n_vec++;
      if (sp_out !== 12'h000 || mem_data_out !== 16'hA5A5) begin
         n_err++; $display("FAIL pop_wrap: sp %h data %h want sp 000 data A5A5", sp_out, mem_data_out);
      end
      idle_inputs(); mem_push = 1'b1; read_data1 = 16'h5A5A;
      tick();
      m_mem[m_sp] = 16'h5A5A; m_sp = m_sp - 1'b1;
      n_vec++;
      if (sp_out !== 12'hFFF) begin
         n_err++; $display("FAIL push_wrap: sp %h want FFF", sp_out);
      end
      for (int r = 0; r < 4; r++) begin
         k = (r == 0) ? 1 : $urandom_range(6, 1);
         for (int unsigned j = 0; j < k; j++) begin
            d = (r == 0) ? 16'h1234 : 16'($urandom);
            idle_inputs();
            mem_push = 1'b1;
            memory_write_src_select = (r == 0) ? 2'b00 : 2'($urandom_range(1, 0));
            if (memory_write_src_select == 2'b01) begin
               read_data2 = d; read_data1 = 16'($urandom);
            end else begin
               read_data1 = d; read_data2 = 16'($urandom);
            end
            // Lower-priority controls raised alongside must lose to push.
            if (r != 0) begin
               mem_pop = 1'($urandom); mem_write = 1'($urandom); mem_read = 1'($urandom);
            end
            #1;
            n_vec++;
            if (stall !== 1'b0) begin
               n_err++; $display("FAIL push_stall: got %b want 0", stall);
            end
            tick();
            m_mem[m_sp] = d; m_sp = m_sp - 1'b1;
            n_vec++;
            if (sp_out !== m_sp) begin
               n_err++; $display("FAIL push_sp: got %h want %h", sp_out, m_sp);
            end
         end
         for (int unsigned j = 0; j < k; j++) begin
            idle_inputs();
            mem_pop = 1'b1;
            if (r != 0) begin
               mem_write = 1'($urandom); mem_read = 1'($urandom);
            end
            tick();
            m_sp = m_sp + 1'b1;
            n_vec++;
            if (sp_out !== m_sp || mem_data_out !== m_mem[m_sp]) begin
               n_err++; $display("FAIL pop: sp %h data %h want sp %h data %h",
                                 sp_out, mem_data_out, m_sp, m_mem[m_sp]);
            end
         end
      end
   endtask

   task automatic test_call_ret();
      logic [31:0] pcs [2];
      pcs[0] = 32'h0001_0020;
      pcs[1] = $urandom;
      for (int i = 0; i < 2; i++) begin
         idle_inputs();
         mem_push = 1'b1; memory_write_src_select = 2'b10; pc_plus_one = pcs[i];
         reg_write = 1'b1; outport_enable = 1'b1;
         #1;
         n_vec++;
         if (stall !== 1'b1) begin
            n_err++; $display("FAIL call_stall1: got %b want 1", stall);
         end
         tick();
         n_vec++;
         if ({reg_write_out, outport_enable_out, stall} !== 3'b000) begin
            n_err++; $display("FAIL call_bubble: rw/oe/stall got %b%b%b want 000",
                              reg_write_out, outport_enable_out, stall);
         end
         tick();
         m_mem[m_sp] = pcs[i][31:16]; m_sp = m_sp - 1'b1;
         m_mem[m_sp] = pcs[i][15:0];  m_sp = m_sp - 1'b1;
         n_vec++;
         if (reg_write_out !== 1'b1 || sp_out !== m_sp) begin
            n_err++; $display("FAIL call_final: rw %b sp %h want rw 1 sp %h", reg_write_out, sp_out, m_sp);
         end
         if (i == 0) begin
            n_vec++;
            if (sp_out !== 12'hFFD) begin
               n_err++; $display("FAIL call_sp: got %h want FFD", sp_out);
            end
            drive_read(12'hFFF);
            tick();
            n_vec++;
            if (mem_data_out !== 16'h0001) begin
               n_err++; $display("FAIL call_hi_word: got %h want 0001", mem_data_out);
            end
            drive_read(12'hFFE);
            tick();
            n_vec++;
            if (mem_data_out !== 16'h0020) begin
               n_err++; $display("FAIL call_lo_word: got %h want 0020", mem_data_out);
            end
         end
      end
      for (int i = 1; i >= 0; i--) begin
         idle_inputs();
         mem_pop = 1'b1; pc_choose_memory = 1'b1; reg_write = 1'b1;
         #1;
         n_vec++;
         if (stall !== 1'b1) begin
            n_err++; $display("FAIL ret_stall1: got %b want 1", stall);
         end
         tick();
         n_vec++;
         if ({pc_from_memory_valid, stall, reg_write_out} !== 3'b000) begin
            n_err++; $display("FAIL ret_word1: valid/stall/rw got %b%b%b want 000",
                              pc_from_memory_valid, stall, reg_write_out);
         end
         tick();
         m_sp = m_sp + 2'd2;
         n_vec++;
         if (pc_from_memory_valid !== 1'b1 || pc_from_memory !== pcs[i] || sp_out !== m_sp) begin
            n_err++; $display("FAIL ret_pc: valid %b pc %h sp %h want 1 %h %h",
                              pc_from_memory_valid, pc_from_memory, sp_out, pcs[i], m_sp);
         end
         idle_inputs();
         tick();
         n_vec++;
         if (pc_from_memory_valid !== 1'b0 || pc_from_memory !== pcs[i]) begin
            n_err++; $display("FAIL ret_hold: valid %b pc %h want 0 %h",
                              pc_from_memory_valid, pc_from_memory, pcs[i]);
         end
         n_vec++;
         if ({conditions_from_memory_pop, flags_from_memory_valid} !== 4'b0000) begin
            n_err++; $display("FAIL ret_noflags: got %b%b want 0000",
                              conditions_from_memory_pop, flags_from_memory_valid);
         end
      end
      n_vec++;
      if (sp_out !== 12'hFFF) begin
         n_err++; $display("FAIL ret_sp: got %h want FFF", sp_out);
      end
   endtask

`ifdef FLAG_SAVE_EN
   task automatic test_int_rti();
      idle_inputs();
      mem_push = 1'b1; memory_write_src_select = 2'b11;
      flag_register = 3'b101; pc_plus_one = 32'h0000_0040;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++;
         if (stall !== (c < 2)) begin
            n_err++; $display("FAIL int_stall%0d: got %b want %b", c, stall, c < 2);
         end
         tick();
      end
      n_vec++;
      if (sp_out !== 12'hFFC) begin
         n_err++; $display("FAIL int_sp: got %h want FFC", sp_out);
      end
      idle_inputs();
      mem_pop = 1'b1; pc_choose_memory = 1'b1;
      tick(); tick(); tick();
      n_vec++;
      if ({pc_from_memory_valid, flags_from_memory_valid} !== 2'b11 ||
          pc_from_memory !== 32'h0000_0040 || conditions_from_memory_pop !== 3'b101) begin
         n_err++; $display("FAIL rti: valid %b%b pc %h flags %b want 11 00000040 101",
                           pc_from_memory_valid, flags_from_memory_valid, pc_from_memory,
                           conditions_from_memory_pop);
      end
      idle_inputs();
      tick();
   endtask
`endif

   task automatic test_reset_mid();
      idle_inputs();
      mem_push = 1'b1; memory_write_src_select = 2'b10; pc_plus_one = 32'h0001_0020;
      reg_write = 1'b1;
      tick();
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      #1;
      m_mem[12'hFFF] = 16'h0001;
      m_sp = SP_RST;
      n_vec++;
      if (sp_out !== SP_RST || stall !== 1'b0) begin
         n_err++; $display("FAIL midreset_sp: sp %h stall %b want FFF 0", sp_out, stall);
      end
      n_vec++;
      if ({mem_data_out, alu_result_out, reg_write_out, outport_enable_out, wb_sel_out,
           reg_write_address_out, pc_from_memory, pc_from_memory_valid} !== 72'd0) begin
         n_err++; $display("FAIL midreset_outputs: pc %h alu %h valid %b want all 0",
                           pc_from_memory, alu_result_out, pc_from_memory_valid);
      end
      tick(); tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      n_vec++;
      if (sp_out !== SP_RST || pc_from_memory_valid !== 1'b0) begin
         n_err++; $display("FAIL midreset_release: sp %h valid %b want FFF 0", sp_out, pc_from_memory_valid);
      end
      drive_read(12'hFFF);
      tick();
      n_vec++;
      if (mem_data_out !== m_mem[12'hFFF]) begin
         n_err++; $display("FAIL midreset_retained_fff: got %h want %h", mem_data_out, m_mem[12'hFFF]);
      end
      drive_read(12'h010);
      tick();
      n_vec++;
      if (mem_data_out !== m_mem[12'h010]) begin
         n_err++; $display("FAIL midreset_retained_010: got %h want %h", mem_data_out, m_mem[12'h010]);
      end
   endtask

   initial begin
      reset = 1'b0;
      alu_result = '0; read_data1 = '0; read_data2 = '0;
      pc_plus_one = '0; flag_register = '0; wb_sel = '0; reg_write_address = '0;
      idle_inputs();
      test_reset();
      test_store_load();
      test_push_pop();
`ifdef FLAG_SAVE_EN
      test_int_rti();
`else
      test_call_ret();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage. Consumes the EX/MEM buffer fields driven by the execute stage: ALU result, operands, memory controls, PC, pc_plus_one and flags.
- Holds data memory and the stack pointer (SP), and sequences 32-bit PC push/pop as two 16-bit words, stalling upstream while it does so.
- Drives the MEM/WB buffer, plus the PC and flag values returned from a pop back to fetch/execute.

Parameters:
ADDR_WIDTH, 12, data-memory address bits; depth = 2**ADDR_WIDTH words of 16 bits; SP reset value = 2**ADDR_WIDTH-1.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
alu_result  input  16  EX/MEM ALU result; used as address when memory_address_select=00
read_data1  input  16  Rdest value; used as address when memory_address_select=01; write data when memory_write_src_select=00
read_data2  input  16  Rsrc value; write data when memory_write_src_select=01
pc_plus_one  input  32  return address for CALL/INT
flag_register  input  3  {C,N,Z} from execute
mem_read, mem_write, mem_push, mem_pop  input  1 each  memory operation controls
memory_address_select  input  2  00 alu_result, 01 read_data1, others treated as 00
memory_write_src_select  input  2  00 read_data1, 01 read_data2, 10 pc_plus_one (2 words), 11 pc_plus_one + flags
pc_choose_memory  input  1  pop is a PC return (RET/RTI), 2 words
reg_write, outport_enable  input  1 each  passed to MEM/WB
wb_sel  input  2  passed to MEM/WB
reg_write_address  input  3  passed to MEM/WB
stall  output  1  upstream must hold the EX/MEM inputs stable while high
mem_data_out  output  16  registered read data
alu_result_out  output  16  registered alu_result
reg_write_out, outport_enable_out  output  1 each  registered
wb_sel_out  output  2  registered
reg_write_address_out  output  3  registered
pc_from_memory  output  32  popped PC {high,low}
pc_from_memory_valid  output  1  one-cycle pulse
conditions_from_memory_pop  output  3  popped flags
flags_from_memory_valid  output  1  one-cycle pulse
sp_out  output  ADDR_WIDTH  current SP

Behaviour:
- Reset (async, reset=0):
  - SP=2**ADDR_WIDTH-1; FSM=IDLE.
  - All registered outputs and stall are 0.
  - Memory array is not cleared and retains its contents across reset.
- Addressing:
  - Push writes mem[SP], then SP=SP-1.
  - Pop reads mem[SP+1], then SP=SP+1.
  - Otherwise the address is the low ADDR_WIDTH bits of the operand selected by memory_address_select.
  - SP arithmetic is modulo 2**ADDR_WIDTH; wrap is silent.
- Writes are synchronous. Reads are combinational from the array and captured into mem_data_out at the clock edge, giving 1-cycle latency to MEM/WB.
- Control precedence:
  - mem_push over mem_pop over mem_write over mem_read.
  - Simultaneous push and pop is illegal; push wins.
- FSM states: IDLE, WORD2, WORD3.
  - IDLE, single-word op: completes in 1 cycle; stall=0.
  - IDLE, push with src 10/11: write high word pc_plus_one[31:16]; stall=1 (combinational in this cycle); go to WORD2.
  - WORD2, push: write low word; stall=0; return to IDLE.
  - IDLE, pop with pc_choose_memory=1: read low word into a holding register; stall=1; go to WORD2.
  - WORD2, pop: read high word; pc_from_memory={high,low}; pc_from_memory_valid pulses in the following cycle; return to IDLE.
- MEM/WB buffer:
  - On non-final cycles of a multi-cycle op, loads a bubble: reg_write_out=0, outport_enable_out=0.
  - The final cycle loads the instruction's fields.
- Reset mid-sequence aborts: FSM=IDLE, SP restored to reset value, no valid pulse. Words already written remain in memory.
- pc_from_memory and conditions_from_memory_pop hold their last values until the next pop.

Optional Feature:
FLAG_SAVE_EN
- Defined:
  - Push with src 11 first writes {13'b0,flag_register}, then the high and low PC words (3 cycles, stall high for 2), passing through WORD3.
  - pc_choose_memory pop reads three words (low, high, flags).
  - conditions_from_memory_pop is updated and flags_from_memory_valid pulses together with pc_from_memory_valid.
- Undefined:
  - Src 11 behaves as src 10.
  - conditions_from_memory_pop=0 and flags_from_memory_valid=0 permanently.
  - WORD3 is not implemented.

Test Plan:
- Assert reset=0 mid-run -> sp_out=0xFFF, stall=0, all outputs 0; after release, a prior mem[0x010] value still readable.
- STD: mem_write, sel 00, alu_result=0x0010, read_data1=0xBEEF; then LDD: mem_read, alu_result=0x0010 -> mem_data_out=0xBEEF one cycle later.
- PUSH read_data1=0x1234 then POP -> sp_out 0xFFF->0xFFE->0xFFF; mem_data_out=0x1234.
- CALL pc_plus_one=0x00010020, src 10:
  - Stall high one cycle; mem[0xFFF]=0x0001, mem[0xFFE]=0x0020; SP=0xFFD; reg_write_out=0 during stall.
  - RET (pc_choose_memory) -> stall one cycle; pc_from_memory=0x00010020 with a 1-cycle valid pulse; SP=0xFFF.
- reset=0 during WORD2 of CALL -> SP=0xFFF, FSM IDLE, no valid pulse; mem[0xFFF]=0x0001 retained.
- FLAG_SAVE_EN: INT src 11, flags=3'b101, pc_plus_one=0x00000040:
  - Stall 2 cycles; SP=0xFFC.
  - RTI -> conditions_from_memory_pop=3'b101 and pc_from_memory=0x00000040, valid pulses coincident.
